// File: rtl/tdm_demux_1_to_n.sv
// TDM receive demultiplexer: frame hunt/lock, per-slot channel registers.
// Optional DEMUX_PARITY_EN adds din_par/par_err and drops bad-parity writes.
module tdm_demux_1_to_n #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              frame_sync,
`ifdef DEMUX_PARITY_EN
  input  logic              din_par,
  output logic              par_err,
`endif
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              locked,
  output logic              sync_err
);

  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [SW-1:0] LAST = SW'(N_CH - 1);
  localparam logic [SW-1:0] ONE  = SW'(1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state;
  state_t          nxt_state;
  logic [SW-1:0]   slot;
  logic [SW-1:0]   nxt_slot;
  logic [SW-1:0]   wr_slot;
  logic [W-1:0]    ch_q [N_CH];
  logic [N_CH-1:0] wr_hot;
  logic            take;
  logic            wr_en;
  logic            err;
  logic            fd;
  logic            par_ok;
  logic            hunt;

`ifdef DEMUX_PARITY_EN
  assign par_ok = ~(^{din, din_par});
`else
  assign par_ok = 1'b1;
`endif

  assign hunt = (state == HUNT);

  // Framing decision for the beat being sampled this cycle
  always_comb begin
    take      = 1'b0;
    err       = 1'b0;
    wr_slot   = '0;
    nxt_slot  = slot;
    nxt_state = state;
    if (din_valid) begin
      if (frame_sync) begin
        take      = 1'b1;
        err       = !hunt && (slot != '0);
        nxt_slot  = ONE;
        nxt_state = LOCKED;
      end else if (!hunt && (slot != '0)) begin
        take    = 1'b1;
        wr_slot = slot;
        if (slot == LAST) begin
          nxt_slot = '0;
        end else begin
          nxt_slot = slot + ONE;
        end
      end else if (!hunt) begin
        err       = 1'b1;
        nxt_slot  = '0;
        nxt_state = HUNT;
      end
    end
  end

  assign wr_en  = take && par_ok;
  assign fd     = take && (wr_slot == LAST);
  assign wr_hot = {{(N_CH-1){1'b0}}, 1'b1} << wr_slot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= '0;
      locked     <= 1'b0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef DEMUX_PARITY_EN
      par_err    <= 1'b0;
`endif
      for (int k = 0; k < N_CH; k++) begin
        ch_q[k] <= '0;
      end
    end else begin
      state      <= nxt_state;
      slot       <= nxt_slot;
      locked     <= (nxt_state == LOCKED);
      ch_valid   <= wr_en ? wr_hot : '0;
      frame_done <= fd;
      sync_err   <= err;
`ifdef DEMUX_PARITY_EN
      par_err    <= din_valid && !par_ok;
`endif
      if (wr_en) begin
        ch_q[wr_slot] <= din;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign ch_data[g*W +: W] = ch_q[g];
  end

endmodule
